// File: rtl/img_pkg.sv
// Shared types and constants for the image stream reader slice.
package img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam int unsigned PIXEL_BITS      = 8;
  localparam int unsigned DEF_WIDTH_BITS  = 7;
  localparam int unsigned DEF_HEIGHT_BITS = 7;

  function automatic logic [PIXEL_BITS-1:0] rom_word(input logic [31:0] a);
    logic [31:0] p;
    p = a * 32'd3;
    return p[PIXEL_BITS-1:0];
  endfunction

endpackage

// File: rtl/input_rom.sv
// Behavioural image ROM: word[a] = 3*a mod 256, registered read with one-cycle latency.
module input_rom
  import img_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_WIDTH_BITS + DEF_HEIGHT_BITS
) (
  input  logic                  clock,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [PIXEL_BITS-1:0] q
);

  always_ff @(posedge clock) begin
    if (rden) q <= rom_word(32'(address));
  end

endmodule

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module pixel_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [CW-1:0]     count_q;
  logic              full, do_push, do_pop;

  assign full    = (count_q == DEPTH_V);
  assign empty_o = (count_q == '0);
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/image_stream_reader.sv
// Self-sequencing raster-scan frame source: reads the image ROM and streams pixels
// with coordinates and SOF/EOL/EOF markers over valid/ready.
module image_stream_reader
  import img_pkg::*;
#(
  parameter int unsigned WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int unsigned HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [PIXEL_BITS-1:0]  oData,
  output logic [WIDTH_BITS-1:0]  oCol,
  output logic [HEIGHT_BITS-1:0] oRow,
  output logic                   oSof,
  output logic                   oEol,
  output logic                   oEof
);

  localparam int unsigned ADDR_WIDTH = WIDTH_BITS + HEIGHT_BITS;
  localparam int unsigned FIFO_W     = PIXEL_BITS + WIDTH_BITS + HEIGHT_BITS + 3;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V    = (CW + 1)'(FIFO_DEPTH);

  state_e                  state_q;
  logic [WIDTH_BITS-1:0]   col_q, pcol_q;
  logic [HEIGHT_BITS-1:0]  row_q, prow_q;
  logic                    psof_q, peol_q, peof_q;
  logic                    inflight_q, busy_q, done_q;

  logic [PIXEL_BITS-1:0]   rom_q;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [FIFO_W-1:0]       push_data, head;
  logic [CW-1:0]           fifo_count;
  logic [CW:0]             occ;
  logic                    fifo_empty, pop, issue, col_max, row_max;

  assign col_max = &col_q;
  assign row_max = &row_q;
  assign addr    = {row_q, col_q};
  assign pop     = oValid && iReady;
  // Occupancy counts the read still in the ROM stage and credits a same-cycle pop.
  assign occ     = {1'b0, fifo_count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);
  assign issue   = (state_q == ST_RUN) && (occ < DEPTH_V);

  input_rom #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rom (
    .clock  (clock),
    .rden   (issue),
    .address(addr),
    .q      (rom_q)
  );

  assign push_data = {rom_q, pcol_q, prow_q, psof_q, peol_q, peof_q};

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DATA_W(FIFO_W)
  ) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push_i (inflight_q),
    .data_i (push_data),
    .pop_i  (pop),
    .data_o (head),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign oValid = !fifo_empty;
  assign {oData, oCol, oRow, oSof, oEol, oEof} = head;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      pcol_q     <= '0;
      prow_q     <= '0;
      psof_q     <= 1'b0;
      peol_q     <= 1'b0;
      peof_q     <= 1'b0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        pcol_q <= col_q;
        prow_q <= row_q;
        psof_q <= (col_q == '0) && (row_q == '0);
        peol_q <= col_max;
        peof_q <= col_max && row_max;
      end
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_q <= ST_RUN;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (col_max && row_max) begin
              state_q <= ST_DRAIN;
            end else begin
              col_q <= col_q + 1'b1;
              if (col_max) row_q <= row_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && oEof) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_reader.sv
// Scoreboard bench for image_stream_reader on a 4x4 image with a 4-entry buffer.
module tb_image_stream_reader;

  localparam int W = 2;
  localparam int H = 2;
  localparam int D = 4;
  localparam int NPIX = (1 << W) * (1 << H);

  logic         clock = 1'b0;
  logic         reset, iStart, iReady;
  logic         oBusy, oDone, oValid, oSof, oEol, oEof;
  logic [7:0]   oData;
  logic [W-1:0] oCol;
  logic [H-1:0] oRow;

  always #5 clock = ~clock;

  image_stream_reader #(
    .WIDTH_BITS (W),
    .HEIGHT_BITS(H),
    .FIFO_DEPTH (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .iStart(iStart),
    .oBusy (oBusy),
    .oDone (oDone),
    .oValid(oValid),
    .iReady(iReady),
    .oData (oData),
    .oCol  (oCol),
    .oRow  (oRow),
    .oSof  (oSof),
    .oEol  (oEol),
    .oEof  (oEof)
  );

  typedef struct packed {
    logic [7:0]   d;
    logic [W-1:0] c;
    logic [H-1:0] r;
    logic         sof, eol, eof;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0, n_fail = 0;
  int    beats = 0, frames = 0, dones = 0;
  bit    active = 0, done_exp = 0, rand_rdy = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: pixel i of a raster scan, value 3*i mod 256.
  function automatic beat_t ref_beat(input int i);
    beat_t b;
    int c, r;
    c = i % (1 << W);
    r = i / (1 << W);
    b.d   = 8'((i * 3) % 256);
    b.c   = W'(c);
    b.r   = H'(r);
    b.sof = (i == 0);
    b.eol = (c == (1 << W) - 1);
    b.eof = (i == NPIX - 1);
    return b;
  endfunction

  // Monitor/model: evaluates what the coming posedge will do.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      active   = 0;
      done_exp = 0;
    end else begin
      check("busy", 32'(oBusy), 32'(active));
      check("done", 32'(oDone), 32'(done_exp));
      if (exp_q.size() == 0) check("idle_valid", 32'(oValid), 32'd0);
      done_exp = 0;
      if (iStart && !active) begin
        active = 1;
        frames++;
        for (int i = 0; i < NPIX; i++) exp_q.push_back(ref_beat(i));
      end
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", 32'({oData, oCol, oRow, oSof, oEol, oEof}), 32'(e));
          beats++;
          if (e.eof) begin
            active   = 0;
            done_exp = 1;
            dones++;
          end
        end
      end
    end
  end

  always @(posedge clock) begin
    #1;
    if (rand_rdy) iReady = 1'($urandom_range(0, 1));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((active || exp_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check(name, 32'd0, 32'd1);
    tick();
    tick();
  endtask

  initial begin
    int b0, d0, f0, n;
    reset  = 1'b1;
    iStart = 1'b0;
    iReady = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_busy",  32'(oBusy),  32'd0);
    check("rst_done",  32'(oDone),  32'd0);
    check("rst_out",   32'({oData, oCol, oRow, oSof, oEol, oEof}), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: latency and a clean frame
    iReady = 1'b1;
    iStart = 1'b1;
    @(posedge clock);
    #1 iStart = 1'b0;
    @(negedge clock); check("lat_e0", 32'(oValid), 32'd0);
    @(negedge clock); check("lat_e1", 32'(oValid), 32'd0);
    @(negedge clock); check("lat_e2", 32'(oValid), 32'd1);
    wait_idle("t1_timeout");

    // 2: backpressure holds the head and stops issuing at the credit limit
    iReady = 1'b0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (6) tick();
    repeat (4) begin
      @(negedge clock);
      check("bp_valid", 32'(oValid), 32'd1);
      check("bp_data",  32'(oData), 32'd0);
      check("bp_count", 32'(dut.fifo_count), 32'(D));
      check("bp_issue", 32'(dut.inflight_q), 32'd0);
    end
    tick();
    iReady = 1'b1;
    repeat (NPIX) begin
      @(negedge clock);
      check("bp_contig", 32'(oValid), 32'd1);
    end
    wait_idle("t2_timeout");

    // 3: random backpressure over three back-to-back frames
    f0 = frames;
    rand_rdy = 1;
    iStart = 1'b1;
    n = 0;
    while (frames < f0 + 3 && n < 3000) begin
      tick();
      n++;
    end
    iStart = 1'b0;
    if (n >= 3000) check("t3_timeout", 32'd0, 32'd1);
    wait_idle("t3_drain");
    rand_rdy = 0;
    tick();
    iReady = 1'b1;
    check("t3_frames", 32'(frames - f0), 32'd3);

    // 4: start pulses during RUN and DRAIN are ignored
    b0 = beats;
    d0 = dones;
    iStart = 1'b1;
    tick();
    for (int k = 1; k < 20; k++) begin
      iStart = (k == 4 || k == 10 || k == 16 || k == 17);
      tick();
    end
    iStart = 1'b0;
    wait_idle("t4_timeout");
    check("t4_beats", 32'(beats - b0), 32'(NPIX));
    check("t4_dones", 32'(dones - d0), 32'd1);

    // 5: reset mid-frame, then restart from pixel 0
    b0 = beats;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    n = 0;
    while (beats < b0 + 7 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("t5_timeout", 32'd0, 32'd1);
    iReady = 1'b0;
    reset  = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t5_valid", 32'(oValid), 32'd0);
    check("t5_busy",  32'(oBusy),  32'd0);
    tick();
    iReady = 1'b1;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    wait_idle("t5_restart");

    // 6: start held high gives back-to-back frames from IDLE only
    f0 = frames;
    iStart = 1'b1;
    repeat (40) tick();
    iStart = 1'b0;
    wait_idle("t6_timeout");
    check("t6_frames", 32'(frames - f0 >= 2), 32'd1);
    check("t6_dones",  32'(dones - d0 - 2 >= frames - f0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
